// File: rtl/environment_timing_pkg.sv
// Shared screen codes and timer state encoding for the environment timing responder.
// Imported by the top level and by the generic interval timer.
package environment_timing_pkg;

    localparam logic [2:0] CODE_NONE     = 3'b000;
    localparam logic [2:0] CODE_START_TR = 3'b001;
    localparam logic [2:0] CODE_LOSE     = 3'b010;
    localparam logic [2:0] CODE_WIN      = 3'b011;
    localparam logic [2:0] CODE_TR1      = 3'b100;
    localparam logic [2:0] CODE_TR2      = 3'b101;
    localparam logic [2:0] CODE_TR3      = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } timer_state_t;

    // Lose and win screens use the long dwell; every other non-idle code uses the short one.
    function automatic logic is_end_code(input logic [2:0] code);
        return (code == CODE_LOSE) || (code == CODE_WIN);
    endfunction

endpackage

// File: rtl/pulse_interval_timer.sv
// Generic Moore interval timer: while run holds, emits a one-cycle low pulse every ticks cycles.
// restart re-arms the period from zero; clear drops straight back to IDLE.
module pulse_interval_timer
    import environment_timing_pkg::*;
#(
    parameter int CW = 28
) (
    input  logic          SC_STATEMACHINE_ENVIRONMENT_CLOCK_50,
    input  logic          SC_STATEMACHINE_ENVIRONMENT_RESET_InLow,
    input  logic          run,
    input  logic          restart,
    input  logic          clear,
    input  logic [CW-1:0] ticks,
    output logic          pulse_low,
    output logic          busy
);

    timer_state_t  state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] terminal;

    // The >= comparison lets a shortened period fire at once instead of counting past it.
    assign terminal = ticks - CW'(2);

    always_ff @(posedge SC_STATEMACHINE_ENVIRONMENT_CLOCK_50 or negedge SC_STATEMACHINE_ENVIRONMENT_RESET_InLow) begin
        if (!SC_STATEMACHINE_ENVIRONMENT_RESET_InLow) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_low <= 1'b1;
            busy      <= 1'b0;
        end else if (clear || !run) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_low <= 1'b1;
            busy      <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                IDLE: begin
                    state     <= COUNT;
                    cnt       <= '0;
                    pulse_low <= 1'b1;
                end
                COUNT: begin
                    if (restart) begin
                        state     <= COUNT;
                        cnt       <= '0;
                        pulse_low <= 1'b1;
                    end else if (cnt >= terminal) begin
                        state     <= FIRE;
                        cnt       <= '0;
                        pulse_low <= 1'b0;
                    end else begin
                        state     <= COUNT;
                        cnt       <= cnt + CW'(1);
                        pulse_low <= 1'b1;
                    end
                end
                FIRE: begin
                    state     <= COUNT;
                    cnt       <= '0;
                    pulse_low <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    pulse_low <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/environment_timing_responder.sv
// Timing partner of the environment screen FSM: dwell expiry pulses for transition/lose/win
// screens and the level-dependent road-scroll tick during play.
module environment_timing_responder
    import environment_timing_pkg::*;
#(
    parameter int CW            = 28,
    parameter int TRAN_TICKS    = 150000000,
    parameter int END_TICKS     = 250000000,
    parameter int DOWN_TICKS_L1 = 5000000,
    parameter int DOWN_TICKS_L2 = 3000000,
    parameter int DOWN_TICKS_L3 = 2000000
) (
    input  logic       SC_STATEMACHINE_ENVIRONMENT_CLOCK_50,
    input  logic       SC_STATEMACHINE_ENVIRONMENT_RESET_InLow,
    input  logic       ENABLECOUNT_InLow,
    input  logic [2:0] SELECTIONTRAN_InBus,
    input  logic       SCREENSELECTOR_In,
    input  logic [2:0] LEVEL_InBus,
    input  logic       CLEAR_InLow,
    output logic       TRANSITION_OutLow,
    output logic       DOWN_OutLow,
    output logic       BUSY_Out
);

    localparam logic [CW-1:0] TRAN_T = CW'(TRAN_TICKS);
    localparam logic [CW-1:0] END_T  = CW'(END_TICKS);
    localparam logic [CW-1:0] L1_T   = CW'(DOWN_TICKS_L1);
    localparam logic [CW-1:0] L2_T   = CW'(DOWN_TICKS_L2);
    localparam logic [CW-1:0] L3_T   = CW'(DOWN_TICKS_L3);

    logic [2:0]    prev_code;
    logic          dwell_run;
    logic          dwell_restart;
    logic [CW-1:0] dwell_ticks;
    logic          scroll_run;
    logic [CW-1:0] scroll_ticks;
    logic          clear;
    logic          scroll_busy_unused;

    // A screen code change while the dwell runs means the FSM moved on; the dwell restarts.
    always_ff @(posedge SC_STATEMACHINE_ENVIRONMENT_CLOCK_50 or negedge SC_STATEMACHINE_ENVIRONMENT_RESET_InLow) begin
        if (!SC_STATEMACHINE_ENVIRONMENT_RESET_InLow) begin
            prev_code <= CODE_NONE;
        end else begin
            prev_code <= SELECTIONTRAN_InBus;
        end
    end

    assign clear         = !CLEAR_InLow;
    assign dwell_run     = !ENABLECOUNT_InLow && (SELECTIONTRAN_InBus != CODE_NONE);
    assign dwell_restart = SELECTIONTRAN_InBus != prev_code;
    assign dwell_ticks   = is_end_code(SELECTIONTRAN_InBus) ? END_T : TRAN_T;
    assign scroll_run    = !SCREENSELECTOR_In && ENABLECOUNT_InLow;

    always_comb begin
        scroll_ticks = L1_T;
        case (LEVEL_InBus)
            3'd2:    scroll_ticks = L2_T;
            3'd3:    scroll_ticks = L3_T;
            default: scroll_ticks = L1_T;
        endcase
    end

    pulse_interval_timer #(.CW(CW)) u_dwell_timer (
        .SC_STATEMACHINE_ENVIRONMENT_CLOCK_50    (SC_STATEMACHINE_ENVIRONMENT_CLOCK_50),
        .SC_STATEMACHINE_ENVIRONMENT_RESET_InLow (SC_STATEMACHINE_ENVIRONMENT_RESET_InLow),
        .run                                     (dwell_run),
        .restart                                 (dwell_restart),
        .clear                                   (clear),
        .ticks                                   (dwell_ticks),
        .pulse_low                               (TRANSITION_OutLow),
        .busy                                    (BUSY_Out)
    );

    pulse_interval_timer #(.CW(CW)) u_scroll_timer (
        .SC_STATEMACHINE_ENVIRONMENT_CLOCK_50    (SC_STATEMACHINE_ENVIRONMENT_CLOCK_50),
        .SC_STATEMACHINE_ENVIRONMENT_RESET_InLow (SC_STATEMACHINE_ENVIRONMENT_RESET_InLow),
        .run                                     (scroll_run),
        .restart                                 (1'b0),
        .clear                                   (clear),
        .ticks                                   (scroll_ticks),
        .pulse_low                               (DOWN_OutLow),
        .busy                                    (scroll_busy_unused)
    );

endmodule

// File: tb/tb_environment_timing_responder.sv
// Self-checking bench: directed timing scenarios plus random traffic against a
// period-elapsed reference model of the dwell and scroll timers.
module tb_environment_timing_responder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable_n;
    logic [2:0] code;
    logic       screen_sel;
    logic [2:0] level;
    logic       clear_n;
    logic       transition_low;
    logic       down_low;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Reference model: "active" plus cycles elapsed in the current period.
    bit         m_d_act, m_d_pulse, m_s_act, m_s_pulse;
    int         m_d_elapsed, m_s_elapsed;
    logic [2:0] m_prev;

    logic       r_en, r_sel, r_clr;
    logic [2:0] r_code, r_lvl;

    environment_timing_responder #(
        .CW(8), .TRAN_TICKS(8), .END_TICKS(12),
        .DOWN_TICKS_L1(6), .DOWN_TICKS_L2(4), .DOWN_TICKS_L3(3)
    ) dut (
        .SC_STATEMACHINE_ENVIRONMENT_CLOCK_50    (clock),
        .SC_STATEMACHINE_ENVIRONMENT_RESET_InLow (reset_n),
        .ENABLECOUNT_InLow                       (enable_n),
        .SELECTIONTRAN_InBus                     (code),
        .SCREENSELECTOR_In                       (screen_sel),
        .LEVEL_InBus                             (level),
        .CLEAR_InLow                             (clear_n),
        .TRANSITION_OutLow                       (transition_low),
        .DOWN_OutLow                             (down_low),
        .BUSY_Out                                (busy)
    );

    always #5 clock = ~clock;

    function automatic int dwellPeriod(input logic [2:0] c);
        return (c == 3'b010 || c == 3'b011) ? 12 : 8;
    endfunction

    function automatic int scrollPeriod(input logic [2:0] l);
        if (l == 3'd2) return 4;
        if (l == 3'd3) return 3;
        return 6;
    endfunction

    task automatic modelReset();
        m_d_act = 0; m_d_pulse = 0; m_d_elapsed = 0;
        m_s_act = 0; m_s_pulse = 0; m_s_elapsed = 0;
        m_prev  = 3'b000;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic modelStep();
        bit d_run, s_run, changed;
        if (!reset_n) begin
            modelReset();
            return;
        end
        d_run   = !enable_n && (code != 3'b000);
        s_run   = !screen_sel && enable_n;
        changed = (code != m_prev);
        m_prev  = code;
        if (!clear_n || !d_run) begin
            m_d_act = 0; m_d_pulse = 0;
        end else if (!m_d_act || changed || m_d_pulse) begin
            m_d_act = 1; m_d_elapsed = 1; m_d_pulse = 0;
        end else begin
            m_d_elapsed++;
            m_d_pulse = (m_d_elapsed >= dwellPeriod(code));
        end
        if (!clear_n || !s_run) begin
            m_s_act = 0; m_s_pulse = 0;
        end else if (!m_s_act || m_s_pulse) begin
            m_s_act = 1; m_s_elapsed = 1; m_s_pulse = 0;
        end else begin
            m_s_elapsed++;
            m_s_pulse = (m_s_elapsed >= scrollPeriod(level));
        end
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %b, expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("transition", transition_low, !m_d_pulse);
        checkOutput("down", down_low, !m_s_pulse);
        checkOutput("busy", busy, m_d_act);
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] c, input logic sel,
                                 input logic [2:0] lvl, input logic clr);
        enable_n   = en;
        code       = c;
        screen_sel = sel;
        level      = lvl;
        clear_n    = clr;
        @(posedge clock);
        modelStep();
        #1;
        checkModel();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 3'b000, 1'b1, 3'd1, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        modelReset();

        // Reset hold, then 50 idle cycles
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 1'b1, 3'd1, 1'b1);
        reset_n = 1'b1;
        idleCycles(50);

        // Short dwell: pulses in cycles 7, 15, 23
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b0, 3'b001, 1'b1, 3'd1, 1'b1);
            checkOutput("dwell_period", transition_low, !(i == 7 || i == 15 || i == 23));
        end
        idleCycles(2);

        // Code change 001->100 restarts the dwell
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b0, (i < 6) ? 3'b001 : 3'b100, 1'b1, 3'd1, 1'b1);
            checkOutput("dwell_restart", transition_low, !(i == 13));
        end
        idleCycles(2);

        // Lose code uses the long dwell
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 3'b010, 1'b1, 3'd1, 1'b1);
            checkOutput("dwell_end", transition_low, !(i == 11));
        end
        idleCycles(2);

        // Scroll at level 1, then level 3 while cnt=3
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, 3'b000, 1'b0, (i < 16) ? 3'd1 : 3'd3, 1'b1);
            checkOutput("scroll_level", down_low,
                        !(i == 5 || i == 11 || i == 16 || i == 19 || i == 22));
        end
        idleCycles(2);

        // One-cycle clear mid-dwell
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 3'b001, 1'b1, 3'd1, (i == 4) ? 1'b0 : 1'b1);
            checkOutput("dwell_clear", transition_low, !(i == 12));
        end
        idleCycles(2);

        // One-cycle clear mid-scroll at level 2
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 3'b000, 1'b0, 3'd2, (i == 2) ? 1'b0 : 1'b1);
            checkOutput("scroll_clear", down_low, !(i == 6 || i == 10));
        end
        idleCycles(2);

        // Asynchronous reset mid-dwell at cnt=5
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'b001, 1'b1, 3'd1, 1'b1);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_tran", transition_low, 1'b1);
        checkOutput("async_rst_down", down_low, 1'b1);
        checkOutput("async_rst_busy", busy, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 3'b001, 1'b1, 3'd1, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 3'b001, 1'b1, 3'd1, 1'b1);
            checkOutput("post_reset", transition_low, !(i == 7));
        end
        idleCycles(2);

        // Random traffic with slowly changing controls
        r_en = 1'b1; r_sel = 1'b0; r_code = 3'b001; r_lvl = 3'd1; r_clr = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) r_en = ~r_en;
            if ($urandom_range(0, 29) == 0) r_sel = ~r_sel;
            if ($urandom_range(0, 24) == 0) r_code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) r_lvl = 3'($urandom_range(0, 7));
            r_clr = ($urandom_range(0, 59) != 0);
            applyStimulus(r_en, r_code, r_sel, r_lvl, r_clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
